chunk_sched_arbiter: RTL and testbench

CHUNK_SCHED_ARBITER -- requirements
Module: chunk_sched_arbiter

---
 rtl/chunk_sched_arbiter_if.sv | 45 ++++
 rtl/chunk_sched_arbiter.sv | 91 +++++++++
 tb/tb_chunk_sched_arbiter.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/chunk_sched_arbiter_if.sv
// Configuration defaults plus the requester/chunk-head bundle shared by the arbiter and its environment.
package TauCfg;
    localparam int WORK_BW = 8;
    localparam int VDIM    = 2;
    localparam int N_ICFG  = 15;
endpackage

interface chunk_sched_arbiter_if #(
    parameter int N_REQ   = 4,
    parameter int WBW     = TauCfg::WORK_BW,
    parameter int VDIM    = TauCfg::VDIM,
    parameter int ICFG_BW = $clog2(TauCfg::N_ICFG + 1)
);
    localparam int SRC_W = $clog2(N_REQ);

    logic [N_REQ-1:0]                     i_req_rdy;
    logic [N_REQ-1:0]                     i_req_ack;
    logic [N_REQ-1:0][VDIM-1:0][WBW-1:0]  i_req_bofs;
    logic [N_REQ-1:0][VDIM-1:0][WBW-1:0]  i_req_aofs;
    logic [N_REQ-1:0][ICFG_BW-1:0]        i_req_beg;
    logic [N_REQ-1:0][ICFG_BW-1:0]        i_req_end;
    logic                                 o_abofs_rdy;
    logic                                 o_abofs_ack;
    logic [VDIM-1:0][WBW-1:0]             o_bofs;
    logic [VDIM-1:0][WBW-1:0]             o_aofs;
    logic [ICFG_BW-1:0]                   o_beg;
    logic [ICFG_BW-1:0]                   o_end;
    logic [SRC_W-1:0]                     o_src;
    logic                                 o_drop_err;
    logic [N_REQ-1:0][15:0]               o_grant_cnt;

    // arbiter side
    modport master (
        input  i_req_rdy, i_req_bofs, i_req_aofs, i_req_beg, i_req_end, o_abofs_ack,
        output i_req_ack, o_abofs_rdy, o_bofs, o_aofs, o_beg, o_end, o_src,
        output o_drop_err, o_grant_cnt
    );

    // requesters + downstream side
    modport slave (
        output i_req_rdy, i_req_bofs, i_req_aofs, i_req_beg, i_req_end, o_abofs_ack,
        input  i_req_ack, o_abofs_rdy, o_bofs, o_aofs, o_beg, o_end, o_src,
        input  o_drop_err, o_grant_cnt
    );
endinterface

// File: rtl/chunk_sched_arbiter.sv
// Round-robin arbiter feeding one registered chunk-head slice; drops requests with beg >= end.
// Define CHUNK_ARB_STAT_EN to build the saturating per-requester grant counters.
module chunk_sched_arbiter #(
    parameter int N_REQ   = 4,
    parameter int WBW     = TauCfg::WORK_BW,
    parameter int VDIM    = TauCfg::VDIM,
    parameter int ICFG_BW = $clog2(TauCfg::N_ICFG + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    chunk_sched_arbiter_if.master bus
);
    localparam int SRC_W = $clog2(N_REQ);
    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    logic [0:0]       state;
    logic [SRC_W-1:0] ptr, sel, ptr_nxt;
    logic             sel_vld, can_load, take, good;

    always_comb begin
        sel     = '0;
        sel_vld = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!sel_vld && bus.i_req_rdy[(int'(ptr) + k) % N_REQ]) begin
                sel_vld = 1'b1;
                sel     = SRC_W'((int'(ptr) + k) % N_REQ);
            end
        end
    end

    // i_rst gating keeps acks quiet while reset is held even though the state already reads EMPTY
    assign can_load = i_rst && (state == EMPTY || bus.o_abofs_ack);
    assign take     = can_load && sel_vld;
    assign good     = bus.i_req_beg[sel] < bus.i_req_end[sel];
    assign ptr_nxt  = (int'(sel) == N_REQ - 1) ? '0 : sel + 1'b1;

    always_comb begin
        bus.i_req_ack = '0;
        if (take) bus.i_req_ack[sel] = 1'b1;
    end

    assign bus.o_abofs_rdy = (state == FULL);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state          <= EMPTY;
            ptr            <= '0;
            bus.o_bofs     <= '0;
            bus.o_aofs     <= '0;
            bus.o_beg      <= '0;
            bus.o_end      <= '0;
            bus.o_src      <= '0;
            bus.o_drop_err <= 1'b0;
        end else begin
            if (state == FULL && bus.o_abofs_ack) state <= EMPTY;
            if (take) begin
                ptr <= ptr_nxt;
                if (good) begin
                    state      <= FULL;
                    bus.o_bofs <= bus.i_req_bofs[sel];
                    bus.o_aofs <= bus.i_req_aofs[sel];
                    bus.o_beg  <= bus.i_req_beg[sel];
                    bus.o_end  <= bus.i_req_end[sel];
                    bus.o_src  <= sel;
                end else begin
                    bus.o_drop_err <= 1'b1;
                end
            end
        end
    end

`ifdef CHUNK_ARB_STAT_EN
    logic [N_REQ-1:0][15:0] cnt;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            cnt <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (take && good && sel == SRC_W'(i) && cnt[i] != 16'hFFFF)
                    cnt[i] <= cnt[i] + 16'd1;
            end
        end
    end

    assign bus.o_grant_cnt = cnt;
`else
    assign bus.o_grant_cnt = '0;
`endif
endmodule

// File: tb/tb_chunk_sched_arbiter.sv
// Directed bench for chunk_sched_arbiter: reset, single load, round-robin streaming, stall, drop, mid-transfer reset, stats.
module tb_chunk_sched_arbiter;
    localparam int N_REQ = 4;
    localparam int WBW   = 8;
    localparam int VDIM  = 2;
    localparam int IBW   = 4;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    chunk_sched_arbiter_if #(.N_REQ(N_REQ), .WBW(WBW), .VDIM(VDIM), .ICFG_BW(IBW)) bus ();

    chunk_sched_arbiter #(.N_REQ(N_REQ), .WBW(WBW), .VDIM(VDIM), .ICFG_BW(IBW)) u_dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic init_payload;
        for (int i = 0; i < N_REQ; i++) begin
            bus.i_req_bofs[i][0] = 8'(16 * i + 1);
            bus.i_req_bofs[i][1] = 8'(16 * i + 2);
            bus.i_req_aofs[i][0] = 8'(16 * i + 3);
            bus.i_req_aofs[i][1] = 8'(16 * i + 4);
            bus.i_req_beg[i]     = 4'(i);
            bus.i_req_end[i]     = 4'(i + 2);
        end
    endtask

    // called one time unit after a rising edge, so the pulse straddles no edge
    task automatic do_reset;
        rst = 1'b0;
        #2;
        rst = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        init_payload();
        bus.i_req_rdy   = 4'hF;
        bus.o_abofs_ack = 1'b0;
        #12;
        n_checks++; if (bus.i_req_ack !== 4'h0) begin n_fail++; $display("FAIL reset_ack got %h exp 0", bus.i_req_ack); end
        n_checks++; if (bus.o_abofs_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_rdy got %b exp 0", bus.o_abofs_rdy); end
        n_checks++; if (bus.o_src !== 2'd0) begin n_fail++; $display("FAIL reset_src got %0d exp 0", bus.o_src); end
        n_checks++; if (bus.o_bofs !== 16'h0 || bus.o_aofs !== 16'h0) begin n_fail++; $display("FAIL reset_ofs got %h/%h exp 0", bus.o_bofs, bus.o_aofs); end
        n_checks++; if (bus.o_beg !== 4'h0 || bus.o_end !== 4'h0) begin n_fail++; $display("FAIL reset_range got %h/%h exp 0", bus.o_beg, bus.o_end); end
        n_checks++; if (bus.o_drop_err !== 1'b0) begin n_fail++; $display("FAIL reset_drop got %b exp 0", bus.o_drop_err); end
        n_checks++; if (bus.o_grant_cnt !== 64'h0) begin n_fail++; $display("FAIL reset_cnt got %h exp 0", bus.o_grant_cnt); end
        bus.i_req_rdy = 4'h0;
        tick();
        rst = 1'b1;
    endtask

    task automatic test_single;
        logic [1:0][7:0] exp_b;
        do_reset();
        bus.i_req_bofs[0][1] = 8'd5;
        bus.i_req_bofs[0][0] = 8'd7;
        bus.i_req_beg[0]     = 4'd1;
        bus.i_req_end[0]     = 4'd4;
        exp_b = {8'd5, 8'd7};
        bus.i_req_rdy = 4'b0001;
        #1;
        n_checks++; if (bus.i_req_ack !== 4'b0001) begin n_fail++; $display("FAIL single_ack got %b exp 0001", bus.i_req_ack); end
        n_checks++; if (bus.o_abofs_rdy !== 1'b0) begin n_fail++; $display("FAIL single_rdy_early got %b exp 0", bus.o_abofs_rdy); end
        tick();
        bus.i_req_rdy = 4'b0000;
        n_checks++; if (bus.o_abofs_rdy !== 1'b1) begin n_fail++; $display("FAIL single_rdy got %b exp 1", bus.o_abofs_rdy); end
        n_checks++; if (bus.o_bofs !== exp_b) begin n_fail++; $display("FAIL single_bofs got %h exp %h", bus.o_bofs, exp_b); end
        n_checks++; if (bus.o_aofs !== {8'd4, 8'd3}) begin n_fail++; $display("FAIL single_aofs got %h exp 0403", bus.o_aofs); end
        n_checks++; if (bus.o_beg !== 4'd1 || bus.o_end !== 4'd4) begin n_fail++; $display("FAIL single_range got %0d/%0d exp 1/4", bus.o_beg, bus.o_end); end
        n_checks++; if (bus.o_src !== 2'd0) begin n_fail++; $display("FAIL single_src got %0d exp 0", bus.o_src); end
        bus.o_abofs_ack = 1'b1;
        #1;
        n_checks++; if (bus.i_req_ack !== 4'h0) begin n_fail++; $display("FAIL single_noack got %b exp 0000", bus.i_req_ack); end
        tick();
        n_checks++; if (bus.o_abofs_rdy !== 1'b0) begin n_fail++; $display("FAIL single_drain got %b exp 0", bus.o_abofs_rdy); end
        n_checks++; if (bus.o_bofs !== exp_b) begin n_fail++; $display("FAIL single_hold got %h exp %h", bus.o_bofs, exp_b); end
        bus.o_abofs_ack = 1'b0;
        init_payload();
    endtask

    task automatic test_back_to_back;
        logic [1:0] exp_src;
        logic [3:0] exp_ack;
        do_reset();
        bus.o_abofs_ack = 1'b1;
        bus.i_req_rdy   = 4'b0101;
        for (int i = 0; i < 6; i++) begin
            exp_src = (i % 2 == 0) ? 2'd0 : 2'd2;
            exp_ack = 4'b0001 << exp_src;
            #1;
            n_checks++; if (bus.i_req_ack !== exp_ack) begin n_fail++; $display("FAIL b2b_ack[%0d] got %b exp %b", i, bus.i_req_ack, exp_ack); end
            tick();
            n_checks++; if (bus.o_abofs_rdy !== 1'b1 || bus.o_src !== exp_src) begin n_fail++; $display("FAIL b2b_src[%0d] got rdy=%b src=%0d exp rdy=1 src=%0d", i, bus.o_abofs_rdy, bus.o_src, exp_src); end
            n_checks++; if (bus.o_bofs !== bus_bofs_exp(exp_src)) begin n_fail++; $display("FAIL b2b_bofs[%0d] got %h exp %h", i, bus.o_bofs, bus_bofs_exp(exp_src)); end
        end
        bus.i_req_rdy = 4'b0000;
        tick();
        n_checks++; if (bus.o_abofs_rdy !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got %b exp 0", bus.o_abofs_rdy); end
        bus.o_abofs_ack = 1'b0;
    endtask

    function automatic logic [15:0] bus_bofs_exp(input logic [1:0] r);
        return {8'(16 * int'(r) + 2), 8'(16 * int'(r) + 1)};
    endfunction

    task automatic test_stall;
        int n_ack;
        do_reset();
        bus.i_req_rdy   = 4'hF;
        bus.o_abofs_ack = 1'b0;
        #1;
        n_checks++; if (bus.i_req_ack !== 4'b0001) begin n_fail++; $display("FAIL stall_first got %b exp 0001", bus.i_req_ack); end
        tick();
        n_ack = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.i_req_ack !== 4'h0) n_ack++;
            n_checks++; if (bus.o_abofs_rdy !== 1'b1 || bus.o_src !== 2'd0 || bus.o_bofs !== bus_bofs_exp(2'd0)) begin n_fail++; $display("FAIL stall_frozen[%0d] got rdy=%b src=%0d bofs=%h exp rdy=1 src=0 bofs=%h", i, bus.o_abofs_rdy, bus.o_src, bus.o_bofs, bus_bofs_exp(2'd0)); end
            tick();
        end
        n_checks++; if (n_ack !== 0) begin n_fail++; $display("FAIL stall_acks got %0d exp 0", n_ack); end
        bus.o_abofs_ack = 1'b1;
        #1;
        n_checks++; if (bus.i_req_ack !== 4'b0010) begin n_fail++; $display("FAIL stall_resume_ack got %b exp 0010", bus.i_req_ack); end
        tick();
        n_checks++; if (bus.o_src !== 2'd1) begin n_fail++; $display("FAIL stall_resume_src got %0d exp 1", bus.o_src); end
        bus.i_req_rdy = 4'h0;
        tick();
        bus.o_abofs_ack = 1'b0;
    endtask

    task automatic test_drop;
        do_reset();
        bus.i_req_beg[1] = 4'd3;
        bus.i_req_end[1] = 4'd3;
        bus.i_req_rdy    = 4'b0010;
        #1;
        n_checks++; if (bus.i_req_ack !== 4'b0010) begin n_fail++; $display("FAIL drop_ack got %b exp 0010", bus.i_req_ack); end
        tick();
        n_checks++; if (bus.o_drop_err !== 1'b1) begin n_fail++; $display("FAIL drop_err got %b exp 1", bus.o_drop_err); end
        n_checks++; if (bus.o_abofs_rdy !== 1'b0) begin n_fail++; $display("FAIL drop_rdy got %b exp 0", bus.o_abofs_rdy); end
        bus.i_req_rdy = 4'hF;
        #1;
        n_checks++; if (bus.i_req_ack !== 4'b0100) begin n_fail++; $display("FAIL drop_ptr got %b exp 0100", bus.i_req_ack); end
        tick();
        n_checks++; if (bus.o_src !== 2'd2 || bus.o_drop_err !== 1'b1) begin n_fail++; $display("FAIL drop_sticky got src=%0d err=%b exp src=2 err=1", bus.o_src, bus.o_drop_err); end
        // malformed request taken while the slice drains: contents survive
        bus.i_req_rdy   = 4'b0010;
        bus.o_abofs_ack = 1'b1;
        #1;
        n_checks++; if (bus.i_req_ack !== 4'b0010) begin n_fail++; $display("FAIL drop_full_ack got %b exp 0010", bus.i_req_ack); end
        tick();
        n_checks++; if (bus.o_abofs_rdy !== 1'b0 || bus.o_src !== 2'd2) begin n_fail++; $display("FAIL drop_full got rdy=%b src=%0d exp rdy=0 src=2", bus.o_abofs_rdy, bus.o_src); end
        bus.i_req_rdy   = 4'h0;
        bus.o_abofs_ack = 1'b0;
        init_payload();
    endtask

    task automatic test_reset_mid;
        do_reset();
        bus.i_req_rdy = 4'b0100;
        tick();
        n_checks++; if (bus.o_abofs_rdy !== 1'b1 || bus.o_src !== 2'd2) begin n_fail++; $display("FAIL mid_load got rdy=%b src=%0d exp rdy=1 src=2", bus.o_abofs_rdy, bus.o_src); end
        bus.i_req_rdy = 4'hF;
        #2;
        rst = 1'b0;
        #1;
        n_checks++; if (bus.o_abofs_rdy !== 1'b0 || bus.o_src !== 2'd0) begin n_fail++; $display("FAIL mid_async got rdy=%b src=%0d exp rdy=0 src=0", bus.o_abofs_rdy, bus.o_src); end
        n_checks++; if (bus.i_req_ack !== 4'h0) begin n_fail++; $display("FAIL mid_ack got %b exp 0000", bus.i_req_ack); end
        rst = 1'b1;
        #1;
        n_checks++; if (bus.i_req_ack !== 4'b0001) begin n_fail++; $display("FAIL mid_restart got %b exp 0001", bus.i_req_ack); end
        tick();
        n_checks++; if (bus.o_src !== 2'd0 || bus.o_abofs_rdy !== 1'b1) begin n_fail++; $display("FAIL mid_src got rdy=%b src=%0d exp rdy=1 src=0", bus.o_abofs_rdy, bus.o_src); end
        bus.i_req_rdy   = 4'h0;
        bus.o_abofs_ack = 1'b1;
        tick();
        bus.o_abofs_ack = 1'b0;
    endtask

    task automatic test_stats;
`ifdef CHUNK_ARB_STAT_EN
        do_reset();
        bus.i_req_rdy   = 4'b1000;
        bus.o_abofs_ack = 1'b1;
        repeat (3) tick();
        n_checks++; if (bus.o_grant_cnt[3] !== 16'd3 || bus.o_grant_cnt[0] !== 16'd0) begin n_fail++; $display("FAIL stat_small got %0d/%0d exp 3/0", bus.o_grant_cnt[3], bus.o_grant_cnt[0]); end
        repeat (69997) tick();
        n_checks++; if (bus.o_grant_cnt[3] !== 16'hFFFF) begin n_fail++; $display("FAIL stat_sat got %h exp ffff", bus.o_grant_cnt[3]); end
        bus.i_req_rdy = 4'h0;
        tick();
        bus.o_abofs_ack = 1'b0;
`else
        n_checks++; if (bus.o_grant_cnt !== 64'h0) begin n_fail++; $display("FAIL stat_off got %h exp 0", bus.o_grant_cnt); end
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_drop();
        test_reset_mid();
        test_stats();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
